data_converter_pipe: RTL and testbench
======================================

DATA_CONVERTER_PIPE -- requirements
Module: data_converter_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  input beat offered.
REQ-005 in_ready  output  1  block can accept input beat.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 in_mode  input  2  per-beat mode: 0 XNOR, 1 INTEG, 2 DIFF, 3 BYPASS.
REQ-008 in_sync  input  1  per-beat history reload flag.
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts output beat.
REQ-011 out_data  output  WIDTH  converted word.

Function
REQ-012 An input beat SHALL be accepted when in_valid && in_ready on a rising edge.
REQ-013 in_ready SHALL equal !out_valid || out_ready (single output register, no combinational path from in_valid).
REQ-014 Latency SHALL be exactly one cycle: accepted beat appears on out_data/out_valid the next cycle.
REQ-015 An output beat SHALL be consumed when out_valid && out_ready; out_valid SHALL drop next cycle unless a new beat is accepted in the same cycle.
REQ-016 While out_valid && !out_ready, out_data SHALL hold and history SHALL not change.
REQ-017 History registers in_prev and out_prev (WIDTH each) SHALL update only on accepted beats: in_prev <= in_data, out_prev <= produced word.
REQ-018 Non-sync beat output: XNOR = ~(in ^ in_prev) ^ out_prev; INTEG = in ^ out_prev; DIFF = in ^ in_prev; BYPASS = in.
REQ-019 Beat with in_sync=1 SHALL output in_data unchanged in every mode and load in_prev = out_prev = in_data.
REQ-020 Mode SHALL be sampled per accepted beat; mode change mid-stream SHALL reuse existing history without flush.
REQ-021 All arithmetic SHALL be bitwise, WIDTH bits, no carries; no overflow conditions exist.
REQ-022 Simultaneous output consume and input accept SHALL sustain one beat per cycle with no bubble.

Reset
REQ-023 On rst assertion, immediately: out_valid=0, out_data=0, in_prev=0, out_prev=0 (and out_parity=0 when compiled in).
REQ-024 in_ready SHALL be 1 while rst is deasserted and out_valid=0; reset mid-transfer SHALL discard the pending output beat.
REQ-025 First beat after reset without in_sync SHALL use zero history.

Configuration
REQ-026 Macro DATA_CONVERTER_PIPE_PARITY_EN, when defined, SHALL add output out_parity (1 bit) = XOR-reduction of the registered out_data, updated with out_data and held under stall.
REQ-027 Without DATA_CONVERTER_PIPE_PARITY_EN the out_parity port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package data_converter_pkg SHALL hold the 2-bit mode enum (MODE_XNOR, MODE_INTEG, MODE_DIFF, MODE_BYPASS) and the mode width constant.
REQ-029 Sub-module data_converter_kernel (combinational, parameter WIDTH) SHALL compute the produced word from in_data, in_mode, in_sync, in_prev, out_prev; the top holds handshake, history and output registers.

Verification (WIDTH=8)
REQ-030 XNOR: sync beat 0x5A -> out 0x5A; next beat 0x5A -> out 0xA5.
REQ-031 INTEG then DIFF: sync 0x0F, 0x01 in INTEG -> 0x0F, 0x0E; feed 0x0F(sync), 0x0E in DIFF -> 0x0F, 0x01 (round trip).
REQ-032 Backpressure: out_valid=1, out_ready=0, in_valid=1 for 3 cycles -> in_ready=0, out_data stable, next beat after release uses unchanged history.
REQ-033 Reset mid-stream: assert rst with out_valid=1 -> out_valid=0 same cycle; after release, XNOR beat 0x00 without sync -> out 0xFF.
REQ-034 Streaming: out_ready=1, in_valid=1 for 16 cycles in BYPASS -> 16 outputs, one per cycle, equal to inputs, latency 1.
REQ-035 With DATA_CONVERTER_PIPE_PARITY_EN: out 0xA5 -> out_parity 0; out 0x01 -> out_parity 1.

Source files
------------

// File: rtl/data_converter_pkg.sv
// Shared mode encoding for the data converter pipe and its kernel.
package data_converter_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_XNOR   = 2'd0,
      MODE_INTEG  = 2'd1,
      MODE_DIFF   = 2'd2,
      MODE_BYPASS = 2'd3
   } mode_t;

endpackage

// File: rtl/data_converter_kernel.sv
// Combinational word converter: computes the produced word from the current
// input, its mode/sync flags and the two history words.
module data_converter_kernel
   import data_converter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  in_data,
   input  logic [MODE_W-1:0] in_mode,
   input  logic              in_sync,
   input  logic [WIDTH-1:0]  in_prev,
   input  logic [WIDTH-1:0]  out_prev,
   output logic [WIDTH-1:0]  produced
);

   always_comb begin
      produced = in_data;
      // A sync beat passes through untouched so both histories restart from it.
      if (!in_sync) begin
         case (mode_t'(in_mode))
            MODE_XNOR:   produced = ~(in_data ^ in_prev) ^ out_prev;
            MODE_INTEG:  produced = in_data ^ out_prev;
            MODE_DIFF:   produced = in_data ^ in_prev;
            MODE_BYPASS: produced = in_data;
            default:     produced = in_data;
         endcase
      end
   end

endmodule

// File: rtl/data_converter_pipe.sv
// One-stage valid/ready converter pipe with history registers.
// Optional out_parity output when DATA_CONVERTER_PIPE_PARITY_EN is defined.
module data_converter_pipe
   import data_converter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [MODE_W-1:0] in_mode,
   input  logic              in_sync,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data
`ifdef DATA_CONVERTER_PIPE_PARITY_EN
   ,
   output logic              out_parity
`endif
);

   // Handshake: a beat moves on a rising edge when valid && ready on that side;
   // in_ready depends only on the output register state and out_ready.
   logic             accept;
   logic [WIDTH-1:0] in_prev;
   logic [WIDTH-1:0] out_prev;
   logic [WIDTH-1:0] produced;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   data_converter_kernel #(.WIDTH(WIDTH)) u_kernel (
      .in_data  (in_data),
      .in_mode  (in_mode),
      .in_sync  (in_sync),
      .in_prev  (in_prev),
      .out_prev (out_prev),
      .produced (produced)
   );

   // History moves only with accepted beats, so a stall freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         in_prev   <= '0;
         out_prev  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= produced;
         in_prev   <= in_data;
         out_prev  <= produced;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DATA_CONVERTER_PIPE_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_parity <= 1'b0;
      end else if (accept) begin
         out_parity <= ^produced;
      end
   end
`endif

endmodule

// File: tb/tb_data_converter_pipe.sv
// Directed bench for data_converter_pipe (WIDTH=8); covers out_parity when
// DATA_CONVERTER_PIPE_PARITY_EN is defined.
module tb_data_converter_pipe;
   import data_converter_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [1:0] in_mode = '0;
   logic       in_sync = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
`ifdef DATA_CONVERTER_PIPE_PARITY_EN
   logic       out_parity;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   data_converter_pipe #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_sync   (in_sync),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DATA_CONVERTER_PIPE_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one beat for one clock edge, then sample 1 time unit after the edge.
   task automatic send(input logic [7:0] d, input mode_t m, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      in_sync  = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // XNOR
      send(8'h5A, MODE_XNOR, 1'b1);
      chk("xnor_sync_valid", out_valid, 1);
      chk("xnor_sync", out_data, 8'h5A);
      send(8'h5A, MODE_XNOR, 1'b0);
      chk("xnor_next", out_data, 8'hA5);
`ifdef DATA_CONVERTER_PIPE_PARITY_EN
      chk("parity_a5", out_parity, 0);
`endif

      // INTEG then DIFF round trip
      send(8'h0F, MODE_INTEG, 1'b1);
      chk("integ_sync", out_data, 8'h0F);
      send(8'h01, MODE_INTEG, 1'b0);
      chk("integ_next", out_data, 8'h0E);
      send(8'h0F, MODE_DIFF, 1'b1);
      chk("diff_sync", out_data, 8'h0F);
      send(8'h0E, MODE_DIFF, 1'b0);
      chk("diff_next", out_data, 8'h01);
`ifdef DATA_CONVERTER_PIPE_PARITY_EN
      chk("parity_01", out_parity, 1);
`endif

      // Mode change without flush: history (0E,01) -> BYPASS 33 -> XNOR 0F
      send(8'h33, MODE_BYPASS, 1'b0);
      chk("bypass_mid", out_data, 8'h33);
      send(8'h0F, MODE_XNOR, 1'b0);
      chk("xnor_after_bypass", out_data, 8'hF0);

      // Output consumed with no new beat -> out_valid drops
      @(posedge clk);
      #1;
      chk("drain_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 1);

      // Backpressure: history is in_prev=0F, out_prev=F0
      out_ready = 1'b0;
      send(8'h11, MODE_INTEG, 1'b0);
      chk("bp_first", out_data, 8'hE1);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'h22;
      in_mode  = MODE_INTEG;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_stall_ready", in_ready, 0);
         chk("bp_stall_data", out_data, 8'hE1);
         chk("bp_stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_after", out_data, 8'hC3);

      // Reset mid-stream with a held output beat
      out_ready = 1'b0;
      #2;
      chk("mid_valid_before", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(8'h00, MODE_XNOR, 1'b0);
      chk("post_rst_xnor", out_data, 8'hFF);

      // Streaming BYPASS: one beat per cycle, latency 1
      in_valid = 1'b1;
      in_mode  = MODE_BYPASS;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i * 13 + 7);
         exp_q.push_back(in_data);
         @(posedge clk);
         #1;
         chk("stream_valid", out_valid, 1);
         chk("stream_ready", in_ready, 1);
         chk("stream_data", out_data, exp_q.pop_front());
      end
      in_valid = 1'b0;
      chk("stream_q_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
      chk("stream_end_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
